jtdsp16_irq: RTL
================

# jtdsp16_irq

Interrupt sequencer for the JTDSP16 core. Samples the external interrupt pin, latches the request, and chooses the instruction boundary at which the program is redirected to the interrupt vector. Drives the `icall` and `shadow` lines used by the XAAU and DAU. Handles `ireturn` and enforces the one-instruction guard after return. Sits beside the instruction decoder and is clocked by the same `cen`.

## Interface
Parameters:
- `SYNC`, default 2: number of synchroniser flops on `irq`; valid range 2–3.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cen` in 1: core clock enable; all state except the synchroniser advances only when `cen`=1.
- `irq` in 1: external interrupt pin; asynchronous, rising-edge triggered.
- `no_int` in 1: decoder reports that the current `cen` slot is not an instruction boundary (second word of a double-word instruction, `pc_halt`, goto/call in flight).
- `ireturn` in 1: decoder has decoded `ireturn`; valid in a `cen` slot.
- `icall` out 1: 1-slot pulse; XAAU saves PC to PI and loads vector 0x001.
- `iack` out 1: external acknowledge; high for the `icall` slot and the following slot.
- `shadow` out 1: 1 = normal execution, 0 = inside ISR. Selects the PC/PI context.
- `pending` out 1: an interrupt edge is latched and not yet serviced.
- `overrun` out 1: sticky flag; an edge arrived while `pending`=1.

## Operation
- Synchroniser: `SYNC` flops clocked every `clk` cycle, independent of `cen`. Output `irq_s`.
- Edge detect: register `irq_l` <= `irq_s` on each `cen`. An edge is a `cen` slot where `irq_s`=1 and `irq_l`=0.
- Pending latch:
  - Edge sets `pending`.
  - Dispatch clears it.
  - Edge and dispatch in the same slot: the edge wins, so `pending` stays 1.
  - Edge while `pending`=1 sets `overrun`. `overrun` clears only on a `cen` slot with `ireturn`=1.
- State machine, states NORM, ISR, GUARD; transitions happen only on `cen` slots:
  - NORM: if `pending`=1 and `no_int`=0, then next slot `icall`=1, `shadow`<=0, clear `pending`, go to ISR. Otherwise stay.
  - ISR: edges still latch. No dispatch (no nesting). `ireturn`=1 sets `shadow`<=1 and goes to GUARD.
  - GUARD: lasts exactly one instruction boundary. The first slot with `no_int`=0 goes to NORM with no dispatch in that slot. Slots with `no_int`=1 hold GUARD. The effect is that one main-program instruction always executes between `ireturn` and the next `icall`.
  - `ireturn` in NORM or GUARD: ignored except for clearing `overrun`.
- `iack`: set with `icall`, held one further `cen` slot, then cleared.
- `no_int` does not affect latching; it only delays dispatch.

## Timing
- Reset values: `icall`=0, `iack`=0, `shadow`=1, `pending`=0, `overrun`=0, state NORM, `irq_l`=1.
  - `irq_l`=1 means a pin already high at reset release is not seen as an edge.
- All outputs are registered.
- Latency, pin rise to `pending`=1: `SYNC` clk cycles, then the next `cen` edge.
- Latency, `pending` to `icall`: one `cen` slot, provided `no_int`=0.
- With `cen` held at 1, `SYNC`=2, and a pin rising before clk edge 0: `pending`=1 after edge 3, `icall`=1 after edge 4.
- `icall` is high for exactly one `cen` period (it stays high across non-`cen` clocks).
- `shadow` falls in the same slot `icall` rises. `shadow` rises in the slot after `ireturn` is sampled.
- Reset mid-ISR: return to NORM immediately, `shadow`=1, pending edge lost.
- `cen`=0 for any stretch: the FSM, `irq_l` and outputs freeze. The synchroniser keeps running, so a pulse that rises and falls entirely between two `cen` slots is missed. Pulses must span at least one `cen` slot plus `SYNC` clocks.

## Test plan
- Basic dispatch (`cen`=1, `SYNC`=2, `no_int`=0): irq rises at cycle 10 → `pending`=1 at cycle 13, `icall`=1 for cycle 14 only, `shadow`=0 from cycle 14, `iack`=1 for cycles 14–15.
- Boundary hold: pending with `no_int`=1 for 3 slots → `icall` delayed exactly 3 slots, rises on the first slot with `no_int`=0.
- No nesting and guard: second edge during ISR → `pending`=1 and `icall` stays 0. `ireturn` → `shadow`=1 next slot. Exactly one slot with `no_int`=0 then passes with `icall`=0, and `icall` fires on the following slot.
- Overrun: two edges before dispatch → `overrun`=1 and a single `icall`. `ireturn` clears `overrun`.
- `cen` divide-by-4: repeat the basic dispatch → same slot counts, and `icall` is high for 4 clk cycles.
- Reset: `irq` held high through reset release → no `icall`. Assert `rst` during ISR → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/jtdsp16_irq.sv
// Interrupt sequencer for the JTDSP16 core: synchronises the irq pin, latches
// rising edges and redirects the program at a safe instruction boundary.
module jtdsp16_irq #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic irq,
    input  logic no_int,
    input  logic ireturn,
    output logic icall,
    output logic iack,
    output logic shadow,
    output logic pending,
    output logic overrun
);

    // state | meaning
    // NORM  | main program running, dispatch allowed at an instruction boundary
    // ISR   | inside the interrupt routine, new edges latch but never dispatch
    // GUARD | after ireturn, waits for one main-program instruction boundary
    typedef enum logic [1:0] {
        NORM  = 2'd0,
        ISR   = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t    st, st_nx;
    logic [SYNC-1:0] sync;
    logic      irq_s;
    logic      irq_l;
    logic      irq_edge;
    logic      dispatch;
    logic      icall_nx, iack_nx, shadow_nx, pending_nx, overrun_nx;

    // Synchroniser presets high so a pin already high at reset release never
    // looks like a fresh edge once irq_l starts tracking it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC-2:0], irq};
        end
    end

    assign irq_s = sync[SYNC-1];

    always_comb begin
        st_nx      = st;
        dispatch   = 1'b0;
        shadow_nx  = shadow;
        case (st)
            NORM: begin
                if (pending && !no_int) begin
                    dispatch  = 1'b1;
                    shadow_nx = 1'b0;
                    st_nx     = ISR;
                end
            end
            ISR: begin
                if (ireturn) begin
                    shadow_nx = 1'b1;
                    st_nx     = GUARD;
                end
            end
            GUARD: begin
                if (!no_int) st_nx = NORM;
            end
            default: begin
                shadow_nx = 1'b1;
                st_nx     = NORM;
            end
        endcase

        // A new edge in the dispatch slot must not be swallowed
        if (irq_edge)      pending_nx = 1'b1;
        else if (dispatch) pending_nx = 1'b0;
        else               pending_nx = pending;

        if (irq_edge && pending) overrun_nx = 1'b1;
        else if (ireturn)        overrun_nx = 1'b0;
        else                     overrun_nx = overrun;

        icall_nx = dispatch;
        iack_nx  = dispatch | icall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= NORM;
            irq_l    <= 1'b1;
            irq_edge <= 1'b0;
            icall    <= 1'b0;
            iack     <= 1'b0;
            shadow   <= 1'b1;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else if (cen) begin
            st       <= st_nx;
            irq_l    <= irq_s;
            irq_edge <= irq_s & ~irq_l;
            icall    <= icall_nx;
            iack     <= iack_nx;
            shadow   <= shadow_nx;
            pending  <= pending_nx;
            overrun  <= overrun_nx;
        end
    end

endmodule
